uart_rcv_param: RTL



---
 rtl/uart_rcv_param.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_rcv_param.sv
// Parametrised UART receiver: 2-FF synchroniser, mid-bit sampling, optional parity,
// one or two stop bits, per-frame parity/framing/overrun status with rdy/clr_rdy handshake.
module uart_rcv_param #(
  parameter int unsigned BAUD_DIV   = 2604,
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] CntLast  = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] CntHalf  = CntW'(BAUD_DIV / 2 - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  armed_q, armed_d;
  logic                  rx_meta_q, rx_s_q;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rdy_q, rdy_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    armed_d      = armed_q;
    rx_data_d    = rx_data_q;
    rdy_d        = rdy_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    done         = 1'b0;

    if (clr_rdy) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        // After a framing error, wait for the line to go high before re-arming.
        if (!armed_q) begin
          armed_d = rx_s_q;
        end else if (!rx_s_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BitW'(1);
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = PARITY_EN ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (cnt_q == CntLast) begin
          perr_d  = PARITY_EN & ((^shift_q) ^ rx_s_q ^ PARITY_ODD);
          bit_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          ferr_d = ferr_q | ~rx_s_q;
          bit_d  = bit_q + BitW'(1);
          // Leave mid-stop-bit so a back-to-back start edge is not missed.
          if (bit_q == StopLast) begin
            state_d = StIdle;
            done    = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Completion takes priority over a coincident clr_rdy.
    if (done) begin
      rx_data_d    = shift_q;
      parity_err_d = perr_q;
      frame_err_d  = ferr_d;
      rdy_d        = 1'b1;
      overrun_d    = rdy_q & ~clr_rdy;
      if (ferr_d) begin
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      armed_q      <= 1'b1;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_data_q    <= '0;
      rdy_q        <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      armed_q      <= armed_d;
      rx_meta_q    <= RX;
      rx_s_q       <= rx_meta_q;
      rx_data_q    <= rx_data_d;
      rdy_q        <= rdy_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rdy        = rdy_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
